// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA sync/blanking generator driven by free-running H/V pixel counters
// Optional macro: VGA_TIMING_CHECK_EN enables the sticky counter-continuity checker (timing_error).
module vga_sync_generator #(
    parameter int H_MAX       = 800,
    parameter int V_MAX       = 525,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIPE_STAGES = 1
) (
    input  logic       normalCLK,
    input  logic       resetN,
    input  logic [9:0] HControl,
    input  logic [9:0] VControl,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       timing_error
);

    // All decode boundaries are 10-bit unsigned values
    localparam logic [9:0] H_LAST    = 10'(H_MAX);
    localparam logic [9:0] V_LAST    = 10'(V_MAX);
    localparam logic [9:0] H_VIS_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } line_state_t;

    // Sync flags are kept as "asserted" bits; polarity is applied only at the outputs
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] cnt;
    } stage_t;

    logic        in_range;
    line_state_t line_state;
    stage_t      stage0;
    stage_t      pipe [PIPE_STAGES];

    // Decode the position within the line; out-of-range counters fall into blanking
    always_comb begin
        in_range   = (HControl <= H_LAST) && (VControl <= V_LAST);
        line_state = BACK;
        if (in_range) begin
            if (HControl < H_VIS_END) begin
                line_state = ACTIVE;
            end else if (HControl < HS_FIRST) begin
                line_state = FRONT;
            end else if (HControl <= HS_LAST) begin
                line_state = SYNC;
            end else begin
                line_state = BACK;
            end
        end
    end

    // Build the unregistered stage; frame_count advances together with the frame_start it belongs to
    always_comb begin
        stage0     = '0;
        stage0.hs  = (line_state == SYNC);
        stage0.vs  = in_range && (VControl >= VS_FIRST) && (VControl <= VS_LAST);
        stage0.vis = (line_state == ACTIVE) && (VControl < V_VIS_END);
        stage0.x   = stage0.vis ? HControl : 10'd0;
        stage0.y   = stage0.vis ? VControl : 10'd0;
        stage0.ls  = (HControl == 10'd0);
        stage0.fs  = (HControl == 10'd0) && (VControl == 10'd0);
        stage0.cnt = pipe[0].cnt + {7'd0, stage0.fs};
    end

    // Delay line matching the colour path; every stage clears to the idle/reset values
    always_ff @(posedge normalCLK or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hsync       = pipe[PIPE_STAGES-1].hs ? SYNC_POL : ~SYNC_POL;
    assign vsync       = pipe[PIPE_STAGES-1].vs ? SYNC_POL : ~SYNC_POL;
    assign video_on    = pipe[PIPE_STAGES-1].vis;
    assign pixel_x     = pipe[PIPE_STAGES-1].x;
    assign pixel_y     = pipe[PIPE_STAGES-1].y;
    assign line_start  = pipe[PIPE_STAGES-1].ls;
    assign frame_start = pipe[PIPE_STAGES-1].fs;
    assign frame_count = pipe[PIPE_STAGES-1].cnt;

`ifdef VGA_TIMING_CHECK_EN
    logic [9:0] h_prev;
    logic [9:0] v_prev;
    logic [9:0] h_exp;
    logic [9:0] v_exp;
    logic       armed;
    logic       err;

    // Predict the next counter pair from the previous one (V steps only on an H wrap)
    always_comb begin
        h_exp = (h_prev == H_LAST) ? 10'd0 : h_prev + 10'd1;
        v_exp = v_prev;
        if (h_prev == H_LAST) begin
            v_exp = (v_prev == V_LAST) ? 10'd0 : v_prev + 10'd1;
        end
    end

    // Sticky discontinuity flag; the first sample after reset only primes the history
    always_ff @(posedge normalCLK or negedge resetN) begin
        if (!resetN) begin
            h_prev <= 10'd0;
            v_prev <= 10'd0;
            armed  <= 1'b0;
            err    <= 1'b0;
        end else begin
            h_prev <= HControl;
            v_prev <= VControl;
            armed  <= 1'b1;
            if (armed && ((HControl != h_exp) || (VControl != v_exp))) begin
                err <= 1'b1;
            end
        end
    end

    assign timing_error = err;
`else
    assign timing_error = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - self-checking bench for vga_sync_generator (1- and 3-stage instances)
module tb_vga_sync_generator;

`ifdef VGA_TIMING_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic       hs1, vs1, von1, ls1, fs1, te1;
    logic [9:0] px1, py1;
    logic [7:0] fc1;
    logic       hs3, vs3, von3, ls3, fs3, te3;
    logic [9:0] px3, py3;
    logic [7:0] fc3;

    always #5 clk = ~clk;

    vga_sync_generator #(.PIPE_STAGES(1)) dut1 (
        .normalCLK(clk), .resetN(rst_n), .HControl(h_cnt), .VControl(v_cnt),
        .hsync(hs1), .vsync(vs1), .video_on(von1), .pixel_x(px1), .pixel_y(py1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1), .timing_error(te1)
    );

    vga_sync_generator #(.PIPE_STAGES(3)) dut3 (
        .normalCLK(clk), .resetN(rst_n), .HControl(h_cnt), .VControl(v_cnt),
        .hsync(hs3), .vsync(vs3), .video_on(von3), .pixel_x(px3), .pixel_y(py3),
        .line_start(ls3), .frame_start(fs3), .frame_count(fc3), .timing_error(te3)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        int h;
        int v;
        int cnt;
    } samp_t;

    out_t o1, o3;
    assign o1 = {hs1, vs1, von1, px1, py1, ls1, fs1, fc1};
    assign o3 = {hs3, vs3, von3, px3, py3, ls3, fs3, fc3};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // What the outputs must be for one sampled counter pair (640x480 numbers, active-low syncs)
    function automatic out_t expect_out(input samp_t s, input bit valid);
        out_t o;
        bit in_rng, hsa, vsa, vis;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (valid) begin
            in_rng = (s.h <= 800) && (s.v <= 525);
            hsa    = in_rng && (s.h >= 656) && (s.h <= 751);
            vsa    = in_rng && (s.v >= 490) && (s.v <= 491);
            vis    = (s.h < 640) && (s.v < 480);
            o.hs   = !hsa;
            o.vs   = !vsa;
            o.von  = vis;
            o.px   = vis ? 10'(s.h) : 10'd0;
            o.py   = vis ? 10'(s.v) : 10'd0;
            o.ls   = (s.h == 0);
            o.fs   = (s.h == 0) && (s.v == 0);
            o.fc   = 8'(s.cnt);
        end
        return o;
    endfunction

    task automatic compare(input string tag, input out_t a, input out_t e);
        check({tag, ".hsync"}, a.hs, e.hs);
        check({tag, ".vsync"}, a.vs, e.vs);
        check({tag, ".video_on"}, a.von, e.von);
        check({tag, ".pixel_x"}, a.px, e.px);
        check({tag, ".pixel_y"}, a.py, e.py);
        check({tag, ".line_start"}, a.ls, e.ls);
        check({tag, ".frame_start"}, a.fs, e.fs);
        check({tag, ".frame_count"}, a.fc, e.fc);
    endtask

    // Model: history of accepted samples per pipeline depth, frame tally and continuity tracker
    samp_t q1[$];
    samp_t q3[$];
    int    frames = 0;
    int    prev_h, prev_v;
    bit    prev_valid = 0;
    bit    err_m = 0;

    initial begin : cmp
        int    sh, sv, eh, ev;
        bit    sr;
        samp_t s, s1, s3;
        forever begin
            @(posedge clk);
            sh = int'(h_cnt);
            sv = int'(v_cnt);
            sr = rst_n;
            #1;
            if (!sr) begin
                q1.delete();
                q3.delete();
                frames     = 0;
                prev_valid = 0;
                err_m      = 0;
            end else begin
                if (sh == 0 && sv == 0) frames++;
                s.h = sh; s.v = sv; s.cnt = frames;
                if (prev_valid) begin
                    eh = (prev_h == 800) ? 0 : prev_h + 1;
                    ev = prev_v;
                    if (prev_h == 800) ev = (prev_v == 525) ? 0 : prev_v + 1;
                    if (eh != sh || ev != sv) err_m = 1;
                end
                prev_h = sh; prev_v = sv; prev_valid = 1;
                q1.push_back(s);
                if (q1.size() > 1) void'(q1.pop_front());
                q3.push_back(s);
                if (q3.size() > 3) void'(q3.pop_front());
            end
            s1 = s; s3 = s;
            if (q1.size() == 1) s1 = q1[0];
            if (q3.size() == 3) s3 = q3[0];
            compare("p1", o1, expect_out(s1, q1.size() == 1));
            compare("p3", o3, expect_out(s3, q3.size() == 3));
            check("p1.timing_error", te1, CHECK_ON ? err_m : 1'b0);
            check("p3.timing_error", te3, CHECK_ON ? err_m : 1'b0);
        end
    end

    task automatic drive(input int h, input int v);
        @(negedge clk);
        rst_n = 1'b1;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
    endtask

    task automatic apply_reset(input int h, input int v);
        @(negedge clk);
        rst_n = 1'b0;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        repeat (2) @(negedge clk);
    endtask

    // Directed stimulus; after drive(n) the outputs on view belong to the previous drive
    initial begin : stim
        int low_cnt, first_low, first_blank, fs_pulses;
        rst_n = 1'b0;
        h_cnt = 10'd700;
        v_cnt = 10'd490;

        // Reset held with counters inside both sync windows
        apply_reset(700, 490);
        check("rst.hsync", hs1, 1);
        check("rst.vsync", vs1, 1);
        check("rst.video_on", von1, 0);
        check("rst.pixel_x", px1, 0);
        check("rst.pixel_y", py1, 0);
        check("rst.strobes", {ls1, fs1}, 0);
        check("rst.frame_count", fc1, 0);
        check("rst.timing_error", te1, 0);
        check("rst.p3_syncs", {hs3, vs3}, 2'b11);

        // One full line on V=0
        low_cnt = 0; first_low = -1; first_blank = -1;
        for (int h = 0; h <= 801; h++) begin
            drive(h, 0);
            if (h >= 1) begin
                if (!hs1) begin
                    low_cnt++;
                    if (first_low < 0) first_low = h - 1;
                end
                if (!von1 && first_blank < 0) first_blank = h - 1;
            end
        end
        check("line.hsync_first_low_h", first_low, 656);
        check("line.hsync_low_clocks", low_cnt, 96);
        check("line.video_off_h", first_blank, 640);

        // Vertical sync window
        for (int v = 489; v <= 493; v++) begin
            drive(100, v);
            if (v > 489) begin
                check("vstep.vsync", vs1, (v - 1 == 490 || v - 1 == 491) ? 0 : 1);
                check("vstep.pixel_y", py1, 0);
            end
        end

        // Out-of-range counters are blanking
        drive(700, 0);
        drive(700, 600);
        check("oor.hsync_inrange", hs1, 0);
        drive(820, 0);
        check("oor.hsync_v_oor", hs1, 1);
        drive(0, 1);
        check("oor.hsync_h_oor", hs1, 1);
        check("oor.video_on", von1, 0);

        // Asynchronous reset mid-line, then pipeline refill
        drive(700, 0);
        drive(701, 0);
        check("async.pre_hsync", hs1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async.hsync", hs1, 1);
        check("async.frame_count", fc1, 0);
        check("async.line_start", ls1, 0);
        drive(10, 5);
        drive(11, 5);
        check("refill.p1_pixel_x", px1, 10);
        check("refill.p1_pixel_y", py1, 5);
        check("refill.p3_pixel_x", px3, 0);
        drive(12, 5);
        drive(13, 5);
        check("refill.p3_pixel_x_late", px3, 10);

        // Frame counting and wrap
        apply_reset(0, 0);
        fs_pulses = 0;
        for (int f = 1; f <= 256; f++) begin
            drive(0, 0);
            fs_pulses += int'(fs1);
            drive(5, 0);
            fs_pulses += int'(fs1);
            if (f <= 3 || f >= 255) begin
                check("frame.count", fc1, f % 256);
                check("frame.start", fs1, 1);
            end
        end
        check("frame.pulses", fs_pulses, 256);

        // Three-stage latency and strobe alignment
        apply_reset(0, 0);
        for (int h = 0; h <= 7; h++) begin
            drive(h, 0);
            if (h >= 3) begin
                check("p3.pixel_x_run", px3, h - 3);
                check("p3.line_start_run", ls3, (h == 3));
                check("p3.frame_start_run", fs3, (h == 3));
            end else begin
                check("p3.pixel_x_fill", px3, 0);
                check("p3.line_start_fill", ls3, 0);
            end
        end

        // Counter continuity: legal wraps, then a 2->7 jump
        apply_reset(799, 10);
        drive(799, 10);
        drive(800, 10);
        drive(0, 11);
        drive(1, 11);
        drive(2, 11);
        drive(7, 11);
        check("tchk.before_jump", te1, 0);
        drive(8, 11);
        check("tchk.after_jump", te1, CHECK_ON);
        drive(9, 11);
        drive(10, 11);
        check("tchk.sticky", te1, CHECK_ON);
        apply_reset(0, 0);
        check("tchk.cleared", te1, 0);

        drive(0, 0);
        drive(1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
